// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: op codes, status-flag bit
// positions and FSM state encoding.
package alu_seq_pkg;

    // ALU op codes. The original set (ASL..FLG) keeps its numbering; the
    // extended ops follow it.
    typedef enum logic [4:0] {
        OP_ASL = 5'd0,
        OP_LSR = 5'd1,
        OP_ROL = 5'd2,
        OP_ROR = 5'd3,
        OP_AND = 5'd4,
        OP_INC = 5'd5,
        OP_FLG = 5'd6,
        OP_ORA = 5'd7,
        OP_EOR = 5'd8,
        OP_DEC = 5'd9,
        OP_ADC = 5'd10,
        OP_SBC = 5'd11,
        OP_CMP = 5'd12,
        OP_BIT = 5'd13
    } alu_op_e;

    // Status register bit positions.
    localparam int FLAG_CARRY     = 0;
    localparam int FLAG_ZERO      = 1;
    localparam int FLAG_INTERRUPT = 2;
    localparam int FLAG_DECIMAL   = 3;
    localparam int FLAG_BREAK     = 4;
    localparam int FLAG_OVERFLOW  = 5;
    localparam int FLAG_NEGATIVE  = 6;
    localparam int FLAGS_W        = 7;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_ADJUST,
        S_HOLD
    } state_e;

    // True for the ops that take a BCD correction pass when D is set.
    function automatic logic is_bcd_op(input logic [4:0] op);
        return (op == OP_ADC) || (op == OP_SBC);
    endfunction

endpackage

// File: rtl/alu_seq_bcd_adjust.sv
// Per-nibble decimal correction for ADC/SBC. Works digit by digit from the
// least significant nibble, rippling the decimal carry/borrow upward.
module bcd_adjust #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             c_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             c_o
);
    localparam int NIB = WIDTH / 4;

    logic [3:0] bn;
    logic [4:0] raw;
    logic [3:0] nib;
    logic       c;

    // Digit-serial add (or add-of-complement for SBC) with +6/-6 correction.
    always_comb begin
        bn    = '0;
        raw   = '0;
        nib   = '0;
        c     = c_i;
        sum_o = '0;
        for (int i = 0; i < NIB; i++) begin
            bn  = sub_i ? ~b_i[4*i +: 4] : b_i[4*i +: 4];
            raw = {1'b0, a_i[4*i +: 4]} + {1'b0, bn} + {4'b0, c};
            if (sub_i) begin
                // raw[4] clear means this digit borrowed: pull back by 6.
                nib = raw[4] ? raw[3:0] : raw[3:0] - 4'd6;
                c   = raw[4];
            end else if (raw > 5'd9) begin
                // Covers both >9 and a binary nibble carry (raw >= 16).
                nib = raw[3:0] + 4'd6;
                c   = 1'b1;
            end else begin
                nib = raw[3:0];
                c   = 1'b0;
            end
            sum_o[4*i +: 4] = nib;
        end
        c_o = c;
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake on both sides. A request is
// captured in IDLE, computed in EXEC, optionally BCD-corrected in ADJUST and
// presented in HOLD until the consumer takes it.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4:0]         alu_op,
    input  logic [WIDTH-1:0]   operand_a,
    input  logic [WIDTH-1:0]   operand_b,
    input  logic [FLAGS_W-1:0] flags_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [FLAGS_W-1:0] flags_out
);
    state_e             state_q;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [FLAGS_W-1:0] fin_q;
    logic [WIDTH-1:0]   result_q;
    logic [FLAGS_W-1:0] flags_q;
    logic               in_ready_q, out_valid_q;

    logic [WIDTH-1:0]   res_d;
    logic [FLAGS_W-1:0] flg_d;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     add_w, cmp_w;
    logic               zn_upd;
    logic               cin;
    logic               dec_path;

    logic [WIDTH-1:0]   bcd_sum;
    logic               bcd_c;

    assign cin      = fin_q[FLAG_CARRY];
    assign dec_path = DECIMAL_EN && is_bcd_op(op_q) && fin_q[FLAG_DECIMAL];

    // Binary datapath on the captured operands; unnamed flags pass through.
    always_comb begin
        res_d  = '0;
        flg_d  = fin_q;
        zn_upd = 1'b0;
        b_eff  = (op_q == OP_SBC) ? ~b_q : b_q;
        add_w  = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        cmp_w  = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ASL: begin
                res_d = {a_q[WIDTH-2:0], 1'b0};
                flg_d[FLAG_CARRY] = a_q[WIDTH-1];
                zn_upd = 1'b1;
            end
            OP_LSR: begin
                res_d = {1'b0, a_q[WIDTH-1:1]};
                flg_d[FLAG_CARRY] = a_q[0];
                zn_upd = 1'b1;
            end
            OP_ROL: begin
                res_d = {a_q[WIDTH-2:0], cin};
                flg_d[FLAG_CARRY] = a_q[WIDTH-1];
                zn_upd = 1'b1;
            end
            OP_ROR: begin
                res_d = {cin, a_q[WIDTH-1:1]};
                flg_d[FLAG_CARRY] = a_q[0];
                zn_upd = 1'b1;
            end
            OP_AND: begin res_d = a_q & b_q; zn_upd = 1'b1; end
            OP_ORA: begin res_d = a_q | b_q; zn_upd = 1'b1; end
            OP_EOR: begin res_d = a_q ^ b_q; zn_upd = 1'b1; end
            OP_INC: begin res_d = a_q + 1'b1; zn_upd = 1'b1; end
            OP_DEC: begin res_d = a_q - 1'b1; zn_upd = 1'b1; end
            OP_FLG: begin res_d = a_q; zn_upd = 1'b1; end
            OP_ADC, OP_SBC: begin
                res_d = add_w[WIDTH-1:0];
                flg_d[FLAG_CARRY]    = add_w[WIDTH];
                flg_d[FLAG_OVERFLOW] = (a_q[WIDTH-1] == b_eff[WIDTH-1]) &&
                                       (add_w[WIDTH-1] != a_q[WIDTH-1]);
                zn_upd = 1'b1;
            end
            OP_CMP: begin
                res_d = a_q;
                flg_d[FLAG_CARRY]    = ~cmp_w[WIDTH];
                flg_d[FLAG_ZERO]     = (cmp_w[WIDTH-1:0] == '0);
                flg_d[FLAG_NEGATIVE] = cmp_w[WIDTH-1];
            end
            OP_BIT: begin
                res_d = a_q;
                flg_d[FLAG_ZERO]     = ((a_q & b_q) == '0);
                flg_d[FLAG_NEGATIVE] = b_q[WIDTH-1];
                flg_d[FLAG_OVERFLOW] = b_q[WIDTH-2];
            end
            default: begin
                res_d = '0;
            end
        endcase
        if (zn_upd) begin
            flg_d[FLAG_ZERO]     = (res_d == '0);
            flg_d[FLAG_NEGATIVE] = res_d[WIDTH-1];
        end
    end

    bcd_adjust #(.WIDTH(WIDTH)) u_bcd (
        .a_i   (a_q),
        .b_i   (b_q),
        .c_i   (cin),
        .sub_i (op_q == OP_SBC),
        .sum_o (bcd_sum),
        .c_o   (bcd_c)
    );

    // Control FSM with registered handshake outputs and result hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            fin_q       <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q       <= alu_op;
                        a_q        <= operand_a;
                        b_q        <= operand_b;
                        fin_q      <= flags_in;
                        in_ready_q <= 1'b0;
                        state_q    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_q <= res_d;
                    flags_q  <= flg_d;
                    if (dec_path) begin
                        state_q <= S_ADJUST;
                    end else begin
                        state_q     <= S_HOLD;
                        out_valid_q <= 1'b1;
                    end
                end
                S_ADJUST: begin
                    // Z/N/V stay from the binary pass; only C comes from BCD.
                    result_q             <= bcd_sum;
                    flags_q[FLAG_CARRY]  <= bcd_c;
                    state_q              <= S_HOLD;
                    out_valid_q          <= 1'b1;
                end
                S_HOLD: begin
                    // Going back through IDLE keeps the retire cycle closed to
                    // new requests.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags_out = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a vector table of single operations plus
// hand-written sequences for reset, backpressure and the 16-bit instance.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // 8-bit instance
    logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
    logic [4:0] alu_op = '0;
    logic [7:0] a = '0, b = '0, result;
    logic [6:0] fin = '0, fout;

    // 16-bit instance
    logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0;
    logic [4:0]  alu_op16 = '0;
    logic [15:0] a16 = '0, b16 = '0, result16;
    logic [6:0]  fin16 = '0, fout16;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .operand_a(a), .operand_b(b), .flags_in(fin),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .flags_out(fout)
    );

    alu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
        .alu_op(alu_op16), .operand_a(a16), .operand_b(b16), .flags_in(fin16),
        .out_valid(out_valid16), .out_ready(out_ready16), .result(result16),
        .flags_out(fout16)
    );

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [6:0] f;
        logic [7:0] r;
        logic [6:0] fl;
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [4:0] op, input logic [7:0] aa, bb,
                       input logic [6:0] ff, input logic [7:0] rr,
                       input logic [6:0] fl, input int lat);
        vec_t v;
        v.op = op; v.a = aa; v.b = bb; v.f = ff; v.r = rr; v.fl = fl; v.lat = lat;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one op on the 8-bit DUT; returns once out_valid is seen (or the
    // cycle budget runs out), sampled 1 time unit after the clock edge.
    task automatic run_op(input logic [4:0] op, input logic [7:0] aa, bb,
                          input logic [6:0] ff, output logic [7:0] r,
                          output logic [6:0] f, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        alu_op = op; a = aa; b = bb; fin = ff; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        r = result;
        f = fout;
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] r, r0;
        logic [6:0] f, f0;
        int lat;
        bit seen;

        // Flags: C=0 Z=1 I=2 D=3 B=4 V=5 N=6
        add(OP_ADC, 8'h50, 8'h50, 7'h00, 8'hA0, 7'h60, 2);
        add(OP_ADC, 8'h19, 8'h28, 7'h08, 8'h47, 7'h08, 3);
        add(OP_ADC, 8'h99, 8'h01, 7'h08, 8'h00, 7'h49, 3);
        add(OP_ADC, 8'hFF, 8'h00, 7'h01, 8'h00, 7'h03, 2);
        add(OP_SBC, 8'h50, 8'hB0, 7'h01, 8'hA0, 7'h60, 2);
        add(OP_SBC, 8'h42, 8'h15, 7'h09, 8'h27, 7'h09, 3);
        add(OP_CMP, 8'h10, 8'h20, 7'h20, 8'h10, 7'h60, 2);
        add(OP_BIT, 8'h0F, 8'hC0, 7'h00, 8'h0F, 7'h62, 2);
        add(OP_ASL, 8'h81, 8'h00, 7'h00, 8'h02, 7'h01, 2);
        add(OP_LSR, 8'h01, 8'h00, 7'h01, 8'h00, 7'h03, 2);
        add(OP_ROL, 8'h80, 8'h00, 7'h01, 8'h01, 7'h01, 2);
        add(OP_ROR, 8'h02, 8'h00, 7'h01, 8'h81, 7'h40, 2);
        add(OP_AND, 8'hF0, 8'h0F, 7'h04, 8'h00, 7'h06, 2);
        add(OP_ORA, 8'h80, 8'h01, 7'h01, 8'h81, 7'h41, 2);
        add(OP_EOR, 8'hFF, 8'hFF, 7'h40, 8'h00, 7'h02, 2);
        add(OP_INC, 8'hFF, 8'h00, 7'h01, 8'h00, 7'h03, 2);
        add(OP_DEC, 8'h00, 8'h00, 7'h00, 8'hFF, 7'h40, 2);
        add(OP_FLG, 8'h80, 8'h00, 7'h1C, 8'h80, 7'h5C, 2);
        add(5'h1F,  8'h12, 8'h34, 7'h7F, 8'h00, 7'h7F, 2);

        // Reset, with in_valid asserted to show reset wins.
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", fout, 0);
        in_valid = 1'b0;
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].f, r, f, lat);
            check($sformatf("v%0d_result", i), r, vecs[i].r);
            check($sformatf("v%0d_flags", i), f, vecs[i].fl);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            retire();
        end

        // Backpressure: output frozen for 5 cycles, no acceptance, then retire.
        run_op(OP_ADC, 8'h50, 8'h50, 7'h00, r0, f0, lat);
        check("bp_first_result", r0, 8'hA0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d_valid", k), out_valid, 1);
            check($sformatf("bp%0d_result", k), result, 8'hA0);
            check($sformatf("bp%0d_flags", k), fout, 7'h60);
            check($sformatf("bp%0d_in_ready", k), in_ready, 0);
        end
        out_ready = 1'b1;
        check("bp_retire_in_ready", in_ready, 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_after_valid", out_valid, 0);
        check("bp_after_in_ready", in_ready, 1);

        // Reset while a decimal ADC sits in ADJUST.
        @(negedge clk);
        alu_op = OP_ADC; a = 8'h19; b = 8'h28; fin = 7'h08; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("adj_valid_before_rst", out_valid, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("adj_in_ready", in_ready, 1);
        seen = out_valid;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("adj_no_output", seen, 0);

        // 16-bit INC wrap, carry untouched.
        @(negedge clk);
        alu_op16 = OP_INC; a16 = 16'hFFFF; b16 = 16'h0000; fin16 = 7'h01;
        in_valid16 = 1'b1;
        @(posedge clk); #1;
        in_valid16 = 1'b0;
        lat = 1;
        while (!out_valid16 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w16_result", result16, 16'h0000);
        check("w16_flags", fout16, 7'h03);
        check("w16_latency", lat, 2);
        out_ready16 = 1'b1;
        @(posedge clk); #1;
        out_ready16 = 1'b0;
        check("w16_in_ready", in_ready16, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
